// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA test-pattern path.
package vga_pkg;

  localparam int MODE_W_DEF    = 2;
  localparam int NUM_MODES_DEF = 4;

  localparam int MODE_COLORBARS = 0;
  localparam int MODE_CHECKER   = 1;
  localparam int MODE_GRADIENT  = 2;
  localparam int MODE_SOLID     = 3;

  typedef enum logic [1:0] {
    DB_RELEASED     = 2'd0,
    DB_PRESS_WAIT   = 2'd1,
    DB_PRESSED      = 2'd2,
    DB_RELEASE_WAIT = 2'd3
  } db_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Raw push-button conditioner: 2-FF synchronizer, debounce FSM, one-cycle press pulse.
//
// state           | meaning
// DB_RELEASED     | input stable low
// DB_PRESS_WAIT   | input went high, counting consecutive 1s
// DB_PRESSED      | input stable high
// DB_RELEASE_WAIT | input went low, counting consecutive 0s
module btn_debounce
  import vga_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk_pix,
  input  logic reset,
  input  logic btn_raw,
  output logic press
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  always_ff @(posedge clk_pix or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= DB_RELEASED;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  // A bounce during release re-enters DB_PRESSED without a new press event.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;
    unique case (state_q)
      DB_RELEASED: begin
        if (sync2_q) begin
          state_d = DB_PRESS_WAIT;
          cnt_d   = CNT_LOAD;
        end
      end
      DB_PRESS_WAIT: begin
        if (!sync2_q) begin
          state_d = DB_RELEASED;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = DB_PRESSED;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DB_PRESSED: begin
        if (!sync2_q) begin
          state_d = DB_RELEASE_WAIT;
          cnt_d   = CNT_LOAD;
        end
      end
      DB_RELEASE_WAIT: begin
        if (sync2_q) begin
          state_d = DB_PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = DB_RELEASED;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = DB_RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  assign press = press_q;

endmodule

// File: rtl/tpg_mode_ctrl.sv
// TPG mode scheduler: button requests and auto-cycle, applied only at vsync leading edges.
module tpg_mode_ctrl
  import vga_pkg::*;
#(
  parameter int NUM_MODES        = NUM_MODES_DEF,
  parameter int MODE_W           = MODE_W_DEF,
  parameter int DEBOUNCE_CYCLES  = 250000,
  parameter int AUTO_FRAMES      = 120,
  parameter bit VSYNC_ACTIVE_LOW = 1'b1
) (
  input  logic              clk_pix,
  input  logic              reset,
  input  logic              btn_next,
  input  logic              btn_auto,
  input  logic              vsync,
  output logic [MODE_W-1:0] mode,
  output logic              auto_en,
  output logic              frame_start,
  output logic              mode_changed
);

  localparam int                FCNT_W    = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(AUTO_FRAMES - 1);
  localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(NUM_MODES - 1);
  localparam logic [MODE_W-1:0] MODE_RST  = MODE_W'(MODE_COLORBARS);

  logic              press_next, press_auto;
  logic              vs_act, vs_q, fs_raw;
  logic              want_next, auto_req;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic              auto_en_q, auto_en_d;
  logic              pend_next_q, pend_next_d;
  logic              frame_start_q;
  logic              mode_changed_q, mode_changed_d;
  logic [FCNT_W-1:0] fcnt_q, fcnt_d;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_next (
    .clk_pix (clk_pix),
    .reset   (reset),
    .btn_raw (btn_next),
    .press   (press_next)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_auto (
    .clk_pix (clk_pix),
    .reset   (reset),
    .btn_raw (btn_auto),
    .press   (press_auto)
  );

  assign vs_act    = vsync ^ VSYNC_ACTIVE_LOW;
  assign fs_raw    = vs_act & ~vs_q;
  // A press landing on the boundary cycle is folded into this frame's decision.
  assign want_next = pend_next_q | press_next;
  assign auto_req  = auto_en_q & (fcnt_q == FCNT_LAST);

  always_ff @(posedge clk_pix or posedge reset) begin
    if (reset) begin
      vs_q           <= 1'b1;
      mode_q         <= MODE_RST;
      auto_en_q      <= 1'b0;
      pend_next_q    <= 1'b0;
      frame_start_q  <= 1'b0;
      mode_changed_q <= 1'b0;
      fcnt_q         <= '0;
    end else begin
      vs_q           <= vs_act;
      mode_q         <= mode_d;
      auto_en_q      <= auto_en_d;
      pend_next_q    <= pend_next_d;
      frame_start_q  <= fs_raw;
      mode_changed_q <= mode_changed_d;
      fcnt_q         <= fcnt_d;
    end
  end

  always_comb begin
    mode_d         = mode_q;
    auto_en_d      = auto_en_q;
    pend_next_d    = want_next;
    fcnt_d         = fcnt_q;
    mode_changed_d = 1'b0;
    if (fs_raw) begin
      if (want_next | auto_req) begin
        mode_d         = (mode_q == MODE_LAST) ? '0 : mode_q + MODE_W'(1);
        mode_changed_d = 1'b1;
        pend_next_d    = 1'b0;
        fcnt_d         = '0;
      end else if (auto_en_q) begin
        fcnt_d = fcnt_q + FCNT_W'(1);
      end
    end
    if (press_auto) begin
      auto_en_d = ~auto_en_q;
      fcnt_d    = '0;
    end
  end

  assign mode         = mode_q;
  assign auto_en      = auto_en_q;
  assign frame_start  = frame_start_q;
  assign mode_changed = mode_changed_q;

endmodule

// File: doc/tpg_mode_ctrl.md
# tpg_mode_ctrl

Mode scheduler for the pixel test-pattern generator. It takes raw push-button inputs and the vsync output of the VGA timing block, and decides which TPG mode is displayed. Mode changes are applied only at a frame boundary, so a frame never shows two patterns. The block sits between board I/O and the `mode` input of `pixel_tpg` in `vga_top`.

## Interface
- `NUM_MODES`, 4, number of TPG modes; legal range 2..2^MODE_W
- `MODE_W`, 2, width of `mode`
- `DEBOUNCE_CYCLES`, 250000, clk_pix cycles a button must be stable (10 ms at 25 MHz)
- `AUTO_FRAMES`, 120, frames per mode in auto-cycle; must be ≥1
- `VSYNC_ACTIVE_LOW`, 1, polarity of `vsync`
- `clk_pix` input 1: pixel clock, about 25 MHz
- `reset` input 1: asynchronous, active-high reset
- `btn_next` input 1: raw, asynchronous button; each press advances the mode by one
- `btn_auto` input 1: raw, asynchronous button; each press toggles auto-cycle
- `vsync` input 1: vsync from the timing block, synchronous to clk_pix
- `mode` output MODE_W: current TPG mode, registered
- `auto_en` output 1: auto-cycle enabled, registered
- `frame_start` output 1: one-cycle pulse on the vsync leading edge
- `mode_changed` output 1: one-cycle pulse, coincident with `frame_start`, when `mode` updates

## Operation
- **Button path.** Each button goes through a 2-FF synchronizer, then a debounce FSM with 4 states:
  - RELEASED → PRESS_WAIT when input=1.
  - PRESS_WAIT → PRESSED after DEBOUNCE_CYCLES consecutive 1s; a 0 returns the FSM to RELEASED and clears the counter.
  - PRESSED → RELEASE_WAIT when input=0.
  - RELEASE_WAIT → RELEASED after DEBOUNCE_CYCLES consecutive 0s; a 1 returns the FSM to PRESSED.
  - A press event is a one-cycle pulse on the transition into PRESSED. The counter width is $clog2(DEBOUNCE_CYCLES+1).
- **Auto toggle.** A debounced `btn_auto` press toggles `auto_en` immediately, not frame-aligned. Toggling also clears the frame counter.
- **Manual request.** A debounced `btn_next` press sets `pend_next`. Any number of presses within one frame collapse to one advance.
- **Frame detect.** vs_act = vsync XOR VSYNC_ACTIVE_LOW. vs_q is vs_act registered. `frame_start` = vs_act & ~vs_q.
- **Frame counter.** Runs only while `auto_en`=1. It increments on each `frame_start`.
  - An auto request fires at a `frame_start` when the counter equals AUTO_FRAMES-1.
  - At that point the counter wraps to 0; otherwise it increments.
- **Mode advance.** At `frame_start`, if `pend_next` or the auto request is set:
  - mode ← (mode==NUM_MODES-1) ? 0 : mode+1.
  - `mode_changed`=1 and `pend_next` is cleared.
  - A simultaneous manual and auto request gives exactly one advance. In that case the frame counter resets to 0.
- **Manual press during auto.** A manual advance while `auto_en`=1 also resets the frame counter to 0, so the new mode is held a full AUTO_FRAMES.
- **Press on the frame_start cycle.** A press event arriving in the same cycle as `frame_start` is not lost. It is taken at that boundary; equivalently, `pend_next` is OR'ed with the press before the decision.

## Timing
- **Reset values.** mode=0, auto_en=0, frame_start=0, mode_changed=0, pend_next=0, counters=0, both FSMs in RELEASED, synchronizer FFs=0.
- **vs_q resets to 1 (active).** A vsync that is already active when reset releases therefore produces no `frame_start`.
- **Button latency.** From a raw edge to the press pulse: 2 sync cycles plus DEBOUNCE_CYCLES cycles plus 1 cycle.
- **Mode latency.** `mode`, `frame_start` and `mode_changed` change on the clock edge one cycle after vs_act first samples 1. All three are visible in the same cycle, and `mode` is stable for the rest of the frame.
- **Reset mid-operation.** Asynchronous reset clears all state immediately. A pending request is discarded.
- **No combinational paths** from inputs to outputs.

## Structure
- **Shared package `vga_pkg`** holds:
  - MODE_W and NUM_MODES defaults.
  - Mode constants: MODE_COLORBARS=0, MODE_CHECKER=1, MODE_GRADIENT=2, MODE_SOLID=3.
  - The debounce FSM state encoding.
- **Sub-module `btn_debounce`** (synchronizer, FSM and press pulse), parameterized by DEBOUNCE_CYCLES and instantiated twice.

## Test plan
Use DEBOUNCE_CYCLES=4, AUTO_FRAMES=3, NUM_MODES=4, and a 40-cycle frame with vsync low for 4 cycles.
- **Reset:** assert `reset` with vsync held low, release it -> no `frame_start` on the first cycle; mode=0, auto_en=0.
- **Single advance:** one clean `btn_next` press mid-frame -> mode goes 0→1 on the next vsync leading edge, with `mode_changed` and `frame_start` high together for 1 cycle.
- **Debounce:** a `btn_next` glitch of 3 cycles -> no advance. Then 3 distinct presses in one frame -> exactly one advance.
- **Wrap-around:** 4 presses, each in its own frame, starting from mode=3 -> sequence 0,1,2,3.
- **Auto-cycle:** press `btn_auto` -> auto_en=1; mode advances every 3rd `frame_start`. A manual press at frame-count 1 -> one advance and the count restarts at 0. Pressing `btn_auto` again -> auto_en=0 and no further advances.
- **Mid-frame reset:** assert `reset` with pend_next=1 -> mode=0, pend_next=0, and no advance at the next frame.
